dmem_responder: RTL and testbench

Memory-side responder for the CPU's data-memory port. It accepts one load or store request at a time from the MEM stage and services it against an internal word array after a fixed, programmable latency. It returns a one-cycle acknowledge and holds the pipeline with a stall signal until that acknowledge. It replaces the zero-latency data memory and lets the pipeline run against realistic multi-cycle memory timing.

---
 rtl/dmem_responder_pkg.sv | 11 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state type and widths for the data-memory responder
package dmem_responder_pkg;
    localparam int DMEM_LAT_W = 4;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous-write, synchronous-read word array without reset
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];

    // Read returns the contents before a same-edge write.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        rdata <= r_mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the CPU data-memory port
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DMEM_LAT_W-1:0] CNT_INIT = DMEM_LAT_W'(LATENCY - 1);

    dmem_state_t             r_state;
    dmem_state_t             w_state_nx;
    logic [DMEM_LAT_W-1:0]   r_cnt;
    logic [DMEM_LAT_W-1:0]   w_cnt_nx;
    logic                    r_we;
    logic [IDX_W-1:0]        r_idx;
    logic [WORD_W-1:0]       r_wdata;
    logic                    r_bad;
    logic                    r_err;
    logic                    r_load_ok;
    logic [WORD_W-1:0]       r_hold;
    logic                    w_bad;
    logic                    w_exec;
    logic                    w_mem_we;
    logic [WORD_W-1:0]       w_rdata;

    assign w_bad = (addr_i[1:0] != 2'b00) || (|addr_i[31:IDX_W+2]);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_exec     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_state_nx = BUSY;
                    w_cnt_nx   = CNT_INIT;
                end
            end
            BUSY: begin
                if (!req_i) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == '0) begin
                    w_exec     = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_cnt_nx = r_cnt - DMEM_LAT_W'(1);
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && req_i) begin
            r_we    <= we_i;
            r_idx   <= addr_i[IDX_W+1:2];
            r_wdata <= data_i;
            r_bad   <= w_bad;
        end
    end

    // A good load shows the array read port during DONE, then r_hold keeps it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_load_ok <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_err     <= w_exec & r_bad;
            r_load_ok <= w_exec & ~r_we & ~r_bad;
            if (w_exec && !r_we && r_bad) begin
                r_hold <= '0;
            end else if (r_load_ok) begin
                r_hold <= w_rdata;
            end
        end
    end

    assign w_mem_we = w_exec & r_we & ~r_bad;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (w_mem_we),
        .idx   (r_idx),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    assign data_o  = r_load_ok ? w_rdata : r_hold;
    assign ack_o   = (r_state == DONE);
    assign err_o   = r_err;
    assign stall_o = req_i & ~ack_o;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 3 and 1
module tb_dmem_responder;
    localparam int DEPTH = 32;
    localparam int LAT0  = 3;
    localparam int LAT1  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic        ack   [2];
    logic        err   [2];
    logic        stall [2];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .data_i(din[0]), .data_o(dout[0]), .ack_o(ack[0]), .err_o(err[0]), .stall_o(stall[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .data_i(din[1]), .data_o(dout[1]), .ack_o(ack[1]), .err_o(err[1]), .stall_o(stall[1])
    );

    int checks = 0;
    int errors = 0;
    int lat [2];
    logic [31:0] model_mem  [2][DEPTH];
    logic [31:0] model_dout [2];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        bit          exp_err;
        logic [31:0] exp_d;
    } vec_t;
    vec_t tbl [10];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference behaviour: bad = misaligned or beyond the array; loads of bad addresses read 0.
    function automatic void model_apply(int d, bit w, logic [31:0] a, logic [31:0] wd,
                                        output bit e, output logic [31:0] dd);
        int wi;
        e  = ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
        wi = e ? 0 : int'(a / 4);
        if (w) begin
            if (!e) model_mem[d][wi] = wd;
        end else begin
            model_dout[d] = e ? 32'h0 : model_mem[d][wi];
        end
        dd = model_dout[d];
    endfunction

    task automatic run(int d, bit w, logic [31:0] a, logic [31:0] wd,
                       output int n, output bit st_ok, output bit e, output logic [31:0] dd);
        we[d] = w; addr[d] = a; din[d] = wd; req[d] = 1'b1;
        n = 0; st_ok = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ack[d]) break;
            if (stall[d] !== 1'b1) st_ok = 1'b0;
        end
        if (ack[d] && stall[d] !== 1'b0) st_ok = 1'b0;
        e  = err[d];
        dd = dout[d];
    endtask

    task automatic txn_model(int d, bit w, logic [31:0] a, logic [31:0] wd, int exp_wait,
                             string tag, output logic [31:0] dd);
        int n; bit st_ok; bit e; bit exp_e; logic [31:0] exp_d;
        run(d, w, a, wd, n, st_ok, e, dd);
        model_apply(d, w, a, wd, exp_e, exp_d);
        check({tag, " latency"}, n, exp_wait);
        check({tag, " stall"}, st_ok, 1);
        check({tag, " err"}, e, exp_e);
        check({tag, " data"}, dd, exp_d);
    endtask

    task automatic idle(int d, int n);
        req[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle ack", ack[d], 0);
            check("idle data hold", dout[d], model_dout[d]);
        end
    endtask

    initial begin
        logic [31:0] dd;
        int n; bit st_ok; bit e; bit me; logic [31:0] md;
        bit saw; int last; bit pend; bit b2b; int d; int r; logic [31:0] a;

        lat[0] = LAT0; lat[1] = LAT1;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; din[i] = '0;
            model_dout[i] = '0;
        end
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset data", dout[i], 0);
            check("reset ack", ack[i], 0);
            check("reset err", err[i], 0);
            check("reset stall low", stall[i], 0);
        end
        req[0] = 1'b1; #1;
        check("reset stall follows req", stall[0], 1);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int d0 = 0; d0 < 2; d0++) begin
            for (int i = 0; i < DEPTH; i++) begin
                txn_model(d0, 1'b1, 32'(i * 4), $urandom, lat[d0] + 1, "init store", dd);
                idle(d0, 1);
            end
        end

        tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h7C, 32'h12345678, 1'b0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 32'h7C, 32'h0,        1'b0, 32'h12345678};
        tbl[4] = '{1'b0, 32'h80, 32'h0,        1'b1, 32'h0};
        tbl[5] = '{1'b1, 32'h12, 32'hCAFEF00D, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[7] = '{1'b1, 32'h14, 32'h0BADC0DE, 1'b0, 32'hDEADBEEF};
        tbl[8] = '{1'b0, 32'h14, 32'h0,        1'b0, 32'h0BADC0DE};
        tbl[9] = '{1'b0, 32'h03, 32'h0,        1'b1, 32'h0};
        for (int i = 0; i < 10; i++) begin
            run(0, tbl[i].w, tbl[i].a, tbl[i].wd, n, st_ok, e, dd);
            model_apply(0, tbl[i].w, tbl[i].a, tbl[i].wd, me, md);
            check("table latency", n, LAT0 + 1);
            check("table stall", st_ok, 1);
            check("table err", e, tbl[i].exp_err);
            check("table data", dd, tbl[i].exp_d);
            idle(0, 2);
        end

        txn_model(1, 1'b1, 32'h0, 32'h1, LAT1 + 1, "lat1 st0", dd);
        txn_model(1, 1'b0, 32'h0, 32'h0, LAT1 + 2, "lat1 ld0", dd);
        check("lat1 ld0 value", dd, 32'h1);
        txn_model(1, 1'b1, 32'h4, 32'h2, LAT1 + 2, "lat1 st4", dd);
        txn_model(1, 1'b0, 32'h4, 32'h0, LAT1 + 2, "lat1 ld4", dd);
        check("lat1 ld4 value", dd, 32'h2);
        idle(1, 2);

        we[0] = 1'b1; addr[0] = 32'h8; din[0] = 32'h55; req[0] = 1'b1;
        @(negedge clk); @(negedge clk);
        req[0] = 1'b0; #1;
        check("abort stall", stall[0], 0);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0]) saw = 1'b1;
        end
        check("abort no ack", saw, 0);
        txn_model(0, 1'b0, 32'h8, 32'h0, LAT0 + 1, "abort reload", dd);
        idle(0, 1);

        txn_model(0, 1'b0, 32'h10, 32'h0, LAT0 + 1, "pre-reset load", dd);
        idle(0, 1);
        we[0] = 1'b1; addr[0] = 32'hC; din[0] = 32'hAA; req[0] = 1'b1;
        @(negedge clk); @(negedge clk);
        #2 rst_n[0] = 1'b0;
        #1;
        check("midreset data", dout[0], 0);
        check("midreset ack", ack[0], 0);
        check("midreset err", err[0], 0);
        check("midreset stall", stall[0], 1);
        req[0] = 1'b0; model_dout[0] = '0;
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack[0]) saw = 1'b1;
        end
        check("midreset no ack", saw, 0);
        rst_n[0] = 1'b1;
        txn_model(0, 1'b0, 32'hC, 32'h0, LAT0 + 1, "post-reset load", dd);
        idle(0, 1);

        last = 0; pend = 1'b0;
        for (int k = 0; k < 60; k++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 7) a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else if (r == 8) a = 32'(4 * DEPTH + 4 * $urandom_range(0, 63));
            else             a = $urandom;
            b2b = pend && (last == d) && ($urandom_range(0, 1) == 1);
            if (pend && !b2b) idle(last, $urandom_range(1, 3));
            txn_model(d, $urandom_range(0, 1) == 1, a, $urandom,
                      b2b ? lat[d] + 2 : lat[d] + 1, "random", dd);
            pend = 1'b1; last = d;
        end
        if (pend) idle(last, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
